sample_capture: RTL

SAMPLE_CAPTURE -- requirements
Module: sample_capture

---
 rtl/sample_capture_if.sv | 38 +++
 rtl/sample_capture.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sample_capture_if.sv
// Host/DDS-side signal bundle for sample_capture; trig_level exists only
// when SAMPLE_CAPTURE_TRIG_EN is defined.
interface sample_capture_if #(
  parameter int DEPTH_LOG2 = 10
);
  logic [15:0]         sample_in;
  logic                sample_valid;
  logic                arm;
  logic [15:0]         capture_len;
`ifdef SAMPLE_CAPTURE_TRIG_EN
  logic [15:0]         trig_level;
`endif
  logic                rd_en;
  logic [15:0]         rd_data;
  logic [DEPTH_LOG2:0] fill_count;
  logic [1:0]          state;
  logic                done;
  logic                overflow;
  logic                underrun;

  modport master (
    output sample_in, sample_valid, arm, capture_len,
`ifdef SAMPLE_CAPTURE_TRIG_EN
    output trig_level,
`endif
    output rd_en,
    input  rd_data, fill_count, state, done, overflow, underrun
  );

  modport slave (
    input  sample_in, sample_valid, arm, capture_len,
`ifdef SAMPLE_CAPTURE_TRIG_EN
    input  trig_level,
`endif
    input  rd_en,
    output rd_data, fill_count, state, done, overflow, underrun
  );
endinterface

// File: rtl/sample_capture.sv
// Armed sample capture into a 2**DEPTH_LOG2 x 16 FIFO drained by a host read strobe.
// Optional rising-edge trigger in the ARMED state: define SAMPLE_CAPTURE_TRIG_EN.
module sample_capture #(
  parameter int DEPTH_LOG2 = 10
) (
  input logic             clk,
  input logic             reset,
  sample_capture_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef logic [DEPTH_LOG2:0]   cnt_t;
  typedef logic [DEPTH_LOG2-1:0] ptr_t;

  localparam cnt_t DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        fill_q, fill_d;
  cnt_t        cnt_q, cnt_d;
  cnt_t        len_q, len_d;
  logic        ovf_q, ovf_d;
  logic        und_q, und_d;
  logic [15:0] rd_data_q;
  logic        mem_we;
  logic        do_pop;
`ifdef SAMPLE_CAPTURE_TRIG_EN
  logic [15:0] prev_q, prev_d;
  logic        prev_vld_q, prev_vld_d;
`endif

  logic [15:0] mem [DEPTH];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    und_d    = und_q;
    mem_we   = 1'b0;
    do_pop   = 1'b0;
`ifdef SAMPLE_CAPTURE_TRIG_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
`endif
    if (bus.arm) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      fill_d   = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      und_d    = 1'b0;
      if (bus.capture_len == '0 || 32'(bus.capture_len) > DEPTH)
        len_d = DEPTH_C;
      else
        len_d = cnt_t'(bus.capture_len);
`ifdef SAMPLE_CAPTURE_TRIG_EN
      prev_vld_d = 1'b0;
      state_d    = S_ARMED;
`else
      state_d    = S_CAPTURE;
`endif
    end else begin
      if (bus.rd_en) begin
        if (fill_q != '0) do_pop = 1'b1;
        else              und_d  = 1'b1;
      end
      case (state_q)
        S_CAPTURE: begin
          if (bus.sample_valid) begin
            cnt_d = cnt_q + cnt_t'(1);
            // A simultaneous pop frees the slot, so a full FIFO still accepts the write.
            if (fill_q < DEPTH_C || do_pop) mem_we = 1'b1;
            else                            ovf_d  = 1'b1;
            if (cnt_d == len_q) state_d = S_DONE;
          end
        end
`ifdef SAMPLE_CAPTURE_TRIG_EN
        S_ARMED: begin
          if (bus.sample_valid) begin
            prev_d     = bus.sample_in;
            prev_vld_d = 1'b1;
            if (prev_vld_q && prev_q < bus.trig_level &&
                bus.sample_in >= bus.trig_level) begin
              mem_we  = 1'b1;
              cnt_d   = cnt_t'(1);
              state_d = (len_q == cnt_t'(1)) ? S_DONE : S_CAPTURE;
            end
          end
        end
`endif
        default: ;
      endcase
      if (mem_we) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({mem_we, do_pop})
        2'b10:   fill_d = fill_q + cnt_t'(1);
        2'b01:   fill_d = fill_q - cnt_t'(1);
        default: fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      len_q    <= DEPTH_C;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
`ifdef SAMPLE_CAPTURE_TRIG_EN
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
`ifdef SAMPLE_CAPTURE_TRIG_EN
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
`endif
    end
  end

  // Storage kept free of reset so it maps onto a simple dual-port block RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[wr_ptr_q] <= bus.sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset)                     rd_data_q <= '0;
    else if (do_pop)               rd_data_q <= mem[rd_ptr_q];
    else if (bus.arm || bus.rd_en) rd_data_q <= '0;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.fill_count = fill_q;
  assign bus.state      = state_q;
  assign bus.done       = (state_q == S_DONE);
  assign bus.overflow   = ovf_q;
  assign bus.underrun   = und_q;
endmodule
